// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_pkg: shared encodings for the forwarding / hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_MEM_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline <-> hazard controller bundle. Perf counter outputs exist only
// when HAZ_PERF_CNT_EN is defined.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic [REG_AW-1:0]         mem_rd;
  logic                      mem_reg_write;
  logic [REG_AW-1:0]         wb_rd;
  logic                      wb_reg_write;
  logic                      dmem_wait;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall_if;
  logic                      bubble_ex;
  logic                      hold_mem;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]          perf_stall_cyc;
  logic [CNT_W-1:0]          perf_fwd_mem;
  logic [CNT_W-1:0]          perf_fwd_wb;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  modport master (
    output id_rs, id_rs_used, ex_rs, ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_wait, flush,
`ifdef HAZ_PERF_CNT_EN
    input  perf_stall_cyc, perf_fwd_mem, perf_fwd_wb,
`endif
    input  fwd_sel, stall_if, bubble_ex, hold_mem
  );

  modport slave (
    input  id_rs, id_rs_used, ex_rs, ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_wait, flush,
`ifdef HAZ_PERF_CNT_EN
    output perf_stall_cyc, perf_fwd_mem, perf_fwd_wb,
`endif
    output fwd_sel, stall_if, bubble_ex, hold_mem
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// fwd_match: priority compare of one source register against MEM and WB writers.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);
  logic mem_hit_s;
  logic wb_hit_s;

  // Register 0 never matches; the younger MEM result beats WB.
  always_comb begin
    mem_hit_s = mem_we && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == rs);
    wb_hit_s  = wb_we  && (wb_rd  != {REG_AW{1'b0}}) && (wb_rd  == rs);
    if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: per-operand bypass selects plus load-use / memory-wait stall FSM.
// Saturating performance counters are added when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LU_LOAD  = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  hz_state_e               state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r, cnt_nxt_s, cnt_dec_s;
  logic [NUM_SRC-1:0][1:0] sel_s;
  logic [NUM_SRC-1:0][1:0] lu_sel_s;
  logic [NUM_SRC-1:0]      lu_term_s;
  logic                    lu_hit_s;
  logic                    stall_s, bubble_s, hold_s;

  // A load in EX is enough to create the hazard; its write enable is implied.
  logic unused_s;
  assign unused_s = bus.ex_reg_write;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(.REG_AW(REG_AW)) u_fwd (
      .rs     (bus.ex_rs[i*REG_AW +: REG_AW]),
      .mem_rd (bus.mem_rd),
      .mem_we (bus.mem_reg_write),
      .wb_rd  (bus.wb_rd),
      .wb_we  (bus.wb_reg_write),
      .sel    (sel_s[i])
    );
    fwd_match #(.REG_AW(REG_AW)) u_lu (
      .rs     (bus.id_rs[i*REG_AW +: REG_AW]),
      .mem_rd (bus.ex_rd),
      .mem_we (bus.ex_mem_read & bus.id_rs_used[i]),
      .wb_rd  ({REG_AW{1'b0}}),
      .wb_we  (1'b0),
      .sel    (lu_sel_s[i])
    );
    assign lu_term_s[i] = (lu_sel_s[i] == FWD_MEM);
  end

  assign lu_hit_s  = |lu_term_s;
  assign cnt_dec_s = cnt_r - CNT_ONE;

  // State and remaining-stall counter; reset returns to RUN with nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HZ_RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state and stall controls; cnt_r counts LU_STALL cycles still owed.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    hold_s      = 1'b0;
    case (state_r)
      HZ_RUN: begin
        if (bus.flush) begin
          state_nxt_s = HZ_RUN;
        end else if (bus.dmem_wait) begin
          stall_s     = 1'b1;
          hold_s      = 1'b1;
          state_nxt_s = HZ_MEM_WAIT;
        end else if (lu_hit_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt_s = HZ_LU_STALL;
            cnt_nxt_s   = LU_LOAD;
          end else begin
            state_nxt_s = HZ_RUN;
          end
        end else begin
          state_nxt_s = HZ_RUN;
        end
      end
      HZ_LU_STALL: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        if (bus.dmem_wait) begin
          hold_s      = 1'b1;
          state_nxt_s = HZ_MEM_WAIT;
          cnt_nxt_s   = cnt_dec_s;
        end else if (bus.flush) begin
          stall_s     = 1'b0;
          state_nxt_s = HZ_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r <= CNT_ONE) begin
          state_nxt_s = HZ_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_dec_s;
        end
      end
      HZ_MEM_WAIT: begin
        stall_s = 1'b1;
        hold_s  = bus.dmem_wait;
        if (bus.dmem_wait) begin
          state_nxt_s = HZ_MEM_WAIT;
        end else if (cnt_r != CNT_ZERO) begin
          state_nxt_s = HZ_LU_STALL;
        end else begin
          state_nxt_s = HZ_RUN;
        end
      end
      default: begin
        state_nxt_s = HZ_RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  assign bus.fwd_sel   = rst_n ? sel_s : {(2*NUM_SRC){1'b0}};
  assign bus.stall_if  = rst_n & stall_s;
  assign bus.bubble_ex = rst_n & bubble_s;
  assign bus.hold_mem  = rst_n & hold_s;

`ifdef HAZ_PERF_CNT_EN
  localparam int SW = CNT_W + 1;

  logic [CNT_W-1:0] perf_stall_r, perf_mem_r, perf_wb_r;
  logic [2:0]       n_mem_s, n_wb_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + SW'(b);
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Number of operands selecting MEM / WB this cycle.
  always_comb begin
    n_mem_s = 3'd0;
    n_wb_s  = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_s[i] == FWD_MEM) begin
        n_mem_s = n_mem_s + 3'd1;
      end else if (sel_s[i] == FWD_WB) begin
        n_wb_s = n_wb_s + 3'd1;
      end else begin
        n_mem_s = n_mem_s;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_r <= {CNT_W{1'b0}};
      perf_mem_r   <= {CNT_W{1'b0}};
      perf_wb_r    <= {CNT_W{1'b0}};
    end else begin
      perf_stall_r <= sat_add(perf_stall_r, {2'b00, stall_s});
      perf_mem_r   <= sat_add(perf_mem_r, n_mem_s);
      perf_wb_r    <= sat_add(perf_wb_r, n_wb_s);
    end
  end

  assign bus.perf_stall_cyc = perf_stall_r;
  assign bus.perf_fwd_mem   = perf_mem_r;
  assign bus.perf_fwd_wb    = perf_wb_r;
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl: two instances with different
// NUM_SRC / LOAD_LAT; perf saturation is checked when HAZ_PERF_CNT_EN is defined.
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
    bit          on_b;
  } chk_t;
  chk_t sb_q[$];

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REG_AW(5), .NUM_SRC(3), .CNT_W(32)) ia ();
  hazard_fwd_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  ib ();

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(3), .LOAD_LAT(2), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  function automatic logic [10:0] obs_a();
    return {ia.fwd_sel, 2'b00, ia.stall_if, ia.bubble_ex, ia.hold_mem};
  endfunction

  function automatic logic [10:0] obs_b();
    return {2'b00, ib.fwd_sel, 2'b00, ib.stall_if, ib.bubble_ex, ib.hold_mem};
  endfunction

  // sbh = {stall_if, bubble_ex, hold_mem}
  task automatic exp_a(input string tag, input logic [5:0] f, input logic [2:0] sbh);
    chk_t c;
    c.tag = tag; c.exp = {f, 2'b00, sbh}; c.on_b = 1'b0;
    sb_q.push_back(c);
  endtask

  task automatic exp_b(input string tag, input logic [3:0] f, input logic [2:0] sbh);
    chk_t c;
    c.tag = tag; c.exp = {2'b00, f, 2'b00, sbh}; c.on_b = 1'b1;
    sb_q.push_back(c);
  endtask

  task automatic drain();
    chk_t        c;
    logic [10:0] obs;
    while (sb_q.size() > 0) begin
      c   = sb_q.pop_front();
      obs = c.on_b ? obs_b() : obs_a();
      checks++;
      assert (obs === c.exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ia.id_rs = 15'd0; ia.id_rs_used = 3'b000; ia.ex_rs = 15'd0; ia.ex_rd = 5'd0;
    ia.ex_reg_write = 1'b0; ia.ex_mem_read = 1'b0; ia.mem_rd = 5'd0; ia.mem_reg_write = 1'b0;
    ia.wb_rd = 5'd0; ia.wb_reg_write = 1'b0; ia.dmem_wait = 1'b0; ia.flush = 1'b0;
    ib.id_rs = 10'd0; ib.id_rs_used = 2'b00; ib.ex_rs = 10'd0; ib.ex_rd = 5'd0;
    ib.ex_reg_write = 1'b0; ib.ex_mem_read = 1'b0; ib.mem_rd = 5'd0; ib.mem_reg_write = 1'b0;
    ib.wb_rd = 5'd0; ib.wb_reg_write = 1'b0; ib.dmem_wait = 1'b0; ib.flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // Everything that could forward or stall is active while in reset.
    ia.ex_rs = {5'd7, 5'd3, 5'd5}; ia.mem_rd = 5'd5; ia.mem_reg_write = 1'b1;
    ia.wb_rd = 5'd7; ia.wb_reg_write = 1'b1; ia.dmem_wait = 1'b1;
    ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd3; ia.id_rs = {5'd0, 5'd0, 5'd3}; ia.id_rs_used = 3'b001;
    ib.ex_rs = {5'd0, 5'd5}; ib.mem_rd = 5'd5; ib.mem_reg_write = 1'b1; ib.dmem_wait = 1'b1;
    @(posedge clk); #1;
    exp_a("rst_a", 6'b000000, 3'b000);
    exp_b("rst_b", 4'b0000, 3'b000);
    step();
    rst_n = 1'b1;
    clear_inputs();

    // Forwarding priority on the 3-operand instance.
    ia.ex_rs = {5'd0, 5'd0, 5'd5}; ia.mem_rd = 5'd5; ia.mem_reg_write = 1'b1;
    ia.wb_rd = 5'd5; ia.wb_reg_write = 1'b1;
    exp_a("fwd_mem_wins", 6'b000010, 3'b000); step();
    ia.mem_reg_write = 1'b0;
    exp_a("fwd_wb_only", 6'b000001, 3'b000); step();
    ia.mem_reg_write = 1'b1; ia.mem_rd = 5'd0; ia.wb_rd = 5'd0; ia.ex_rs = 15'd0;
    exp_a("fwd_r0", 6'b000000, 3'b000); step();
    ia.ex_rs = {5'd7, 5'd3, 5'd3}; ia.mem_rd = 5'd3; ia.wb_rd = 5'd7;
    exp_a("fwd_3op", 6'b011010, 3'b000); step();
    ia.mem_rd = 5'd7; ia.wb_rd = 5'd3;
    exp_a("fwd_3op_swap", 6'b100101, 3'b000); step();
    clear_inputs();

    // Load-use on LOAD_LAT=2: exactly two stall cycles.
    ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd4; ia.id_rs = {5'd0, 5'd0, 5'd4}; ia.id_rs_used = 3'b001;
    exp_a("lu_c0", 6'b000000, 3'b110); step();
    ia.ex_mem_read = 1'b0;
    exp_a("lu_c1", 6'b000000, 3'b110); step();
    exp_a("lu_done", 6'b000000, 3'b000); step();
    ia.ex_mem_read = 1'b1; ia.id_rs_used = 3'b000;
    exp_a("lu_unused", 6'b000000, 3'b000); step();
    ia.ex_mem_read = 1'b0;
    exp_a("lu_unused_next", 6'b000000, 3'b000); step();
    ia.ex_mem_read = 1'b1; ia.ex_rd = 5'd0; ia.id_rs = 15'd0; ia.id_rs_used = 3'b111;
    exp_a("lu_r0", 6'b000000, 3'b000); step();
    ia.ex_rd = 5'd4; ia.id_rs = {5'd4, 5'd0, 5'd0}; ia.id_rs_used = 3'b100;
    exp_a("lu_op2", 6'b000000, 3'b110); step();
    ia.ex_mem_read = 1'b0;
    exp_a("lu_op2_c1", 6'b000000, 3'b110); step();
    exp_a("lu_op2_done", 6'b000000, 3'b000); step();
    clear_inputs();

    // LOAD_LAT=3 with a 2-cycle memory wait in the second stall cycle.
    ib.ex_mem_read = 1'b1; ib.ex_rd = 5'd4; ib.id_rs = {5'd0, 5'd4}; ib.id_rs_used = 2'b01;
    exp_b("mw_lu_c0", 4'b0000, 3'b110); step();
    ib.ex_mem_read = 1'b0; ib.dmem_wait = 1'b1;
    exp_b("mw_lu_c1", 4'b0000, 3'b111); step();
    exp_b("mw_lu_c2", 4'b0000, 3'b101); step();
    ib.dmem_wait = 1'b0;
    exp_b("mw_lu_c3", 4'b0000, 3'b100); step();
    exp_b("mw_lu_c4", 4'b0000, 3'b110); step();
    exp_b("mw_lu_c5", 4'b0000, 3'b000); step();

    // Flush aborts a load-use stall at once.
    ib.ex_mem_read = 1'b1;
    exp_b("fl_c0", 4'b0000, 3'b110); step();
    ib.ex_mem_read = 1'b0; ib.flush = 1'b1;
    exp_b("fl_c1", 4'b0000, 3'b010); step();
    ib.flush = 1'b0;
    exp_b("fl_c2", 4'b0000, 3'b000); step();

    // Flush is ignored while memory is waiting.
    ib.dmem_wait = 1'b1;
    exp_b("mw_c0", 4'b0000, 3'b101); step();
    ib.flush = 1'b1;
    exp_b("mw_flush", 4'b0000, 3'b101); step();
    ib.dmem_wait = 1'b0;
    exp_b("mw_exit", 4'b0000, 3'b100); step();
    ib.flush = 1'b0;
    exp_b("mw_done", 4'b0000, 3'b000); step();

    // Asynchronous reset in the middle of a stall.
    ib.ex_mem_read = 1'b1;
    exp_b("rs_c0", 4'b0000, 3'b110); step();
    ib.ex_mem_read = 1'b0;
    exp_b("rs_c1", 4'b0000, 3'b110);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b0;
    #1;
    exp_b("rs_async", 4'b0000, 3'b000);
    drain();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_b("rs_after", 4'b0000, 3'b000); step();

`ifdef HAZ_PERF_CNT_EN
    ib.dmem_wait = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    assert (ib.perf_stall_cyc === 4'd15) else begin
      errors++;
      $error("FAIL perf_sat observed=%0d expected=%0d", ib.perf_stall_cyc, 15);
    end
    ib.dmem_wait = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic.
- Produces per-operand bypass selects for NUM_SRC source operands.
- Detects load-use hazards and runs a stall/bubble FSM. Stall length covers LOAD_LAT load latency plus any data-memory wait cycles.
- Sits between the ID/EX pipeline registers and the IF/ID enables. Drives the operand muxes, PC/IF-ID hold and the ID/EX bubble.

Parameters:
- REG_AW, 5: register address width. Register 0 is hardwired zero.
- NUM_SRC, 2: number of source operands per instruction, 1..4.
- LOAD_LAT, 1: stall cycles inserted per load-use hazard, 1..4.
- CNT_W, 32: performance counter width. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  NUM_SRC*REG_AW  source register addresses of the instruction in ID. Operand i occupies bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand i of the ID instruction is actually read.
- ex_rs  in  NUM_SRC*REG_AW  source register addresses in the ID/EX register.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_reg_write  in  1  the instruction in EX writes a register.
- ex_mem_read  in  1  the instruction in EX is a load.
- mem_rd  in  REG_AW  EX/MEM destination register.
- mem_reg_write  in  1  EX/MEM write enable.
- wb_rd  in  REG_AW  MEM/WB destination register.
- wb_reg_write  in  1  MEM/WB write enable.
- dmem_wait  in  1  data memory not ready this cycle.
- flush  in  1  branch/jump redirect; squashes IF/ID.
- fwd_sel  out  2*NUM_SRC  bypass select per EX operand: 00 register file, 01 WB, 10 MEM.
- stall_if  out  1  hold the PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- hold_mem  out  1  hold EX/MEM and MEM/WB while memory waits.

Behaviour:
- Forwarding, combinational, evaluated per operand i:
  - Select MEM (10) if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs[i].
  - Otherwise select WB (01) if the same three conditions hold for wb_rd/wb_reg_write.
  - Otherwise select 00.
  - MEM always wins over WB. All operands update on any input change. There is no stale sensitivity.
- Load-use hazard (lu_hit): ex_mem_read, ex_rd!=0, and ex_rd==id_rs[i] with id_rs_used[i]=1 for any i.
- FSM states: RUN, LU_STALL, MEM_WAIT. A down-counter stall_cnt is ceil(log2(LOAD_LAT+1)) bits.
  - RUN:
    - If flush: stay in RUN with no stall.
    - Else if dmem_wait: go to MEM_WAIT.
    - Else if lu_hit: go to LU_STALL and load stall_cnt=LOAD_LAT-1.
  - LU_STALL:
    - stall_if=1 and bubble_ex=1 every cycle in this state.
    - On stall_cnt==0 return to RUN. Otherwise decrement.
    - dmem_wait has priority: go to MEM_WAIT and preserve stall_cnt.
  - MEM_WAIT:
    - stall_if=1, hold_mem=1, bubble_ex=0.
    - When dmem_wait drops, resume LU_STALL if stall_cnt is pending. Otherwise go to RUN.
- Outputs in RUN are combinational from inputs for the entry cycle:
  - On the lu_hit cycle, stall_if=bubble_ex=1 (first stall cycle).
  - On the dmem_wait cycle, stall_if=hold_mem=1.
  - Total stall for one hazard is exactly LOAD_LAT cycles when dmem_wait stays low.
- flush in LU_STALL: abort immediately, go to RUN, clear stall_cnt, deassert stall_if the same cycle. bubble_ex stays 1 that cycle.
- flush in MEM_WAIT is ignored until dmem_wait clears. Memory integrity takes precedence.
- Reset: state=RUN, stall_cnt=0.
  - While rst_n=0, stall_if, bubble_ex and hold_mem are 0 and fwd_sel is all 00.
  - Reset mid-stall ends the stall immediately (asynchronous).
- Register 0 never forwards and never causes a stall.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cyc, perf_fwd_mem and perf_fwd_wb, each CNT_W bits.
  - Each counts stall_if cycles, MEM-select operand-cycles and WB-select operand-cycles respectively.
  - Counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - FSM state encoding HZ_RUN, HZ_LU_STALL, HZ_MEM_WAIT.
- Sub-module fwd_match: one operand's priority compare (rs, mem_rd/we, wb_rd/we to 2-bit select).
  - Instantiated NUM_SRC times in a generate loop.
  - Also reused for the lu_hit compare terms.

Test Plan:
- ex_rs[0]=5, mem_rd=5/we=1, wb_rd=5/we=1 -> fwd_sel[1:0]=10. Drop mem we -> 01. Set rd=0 with both we=1 -> 00.
- NUM_SRC=3, ex_rs={7,3,3}, mem_rd=3, wb_rd=7, both we=1 -> fwd_sel=01_10_10.
- LOAD_LAT=2: load to r4 in EX, ID reads r4 with used=1 -> stall_if/bubble_ex high exactly 2 cycles, then 0. Repeat with used=0 -> no stall.
- LOAD_LAT=3 hazard, dmem_wait high for 2 cycles during the 2nd stall cycle -> hold_mem 2 cycles, total stall_if 5 cycles, bubble_ex 3 cycles.
- flush asserted in the 1st LU_STALL cycle -> state RUN the next cycle, stall_if 0 that cycle. rst_n pulsed mid-stall -> all outputs 0 asynchronously.
- With HAZ_PERF_CNT_EN and CNT_W=4: 20 forced stall cycles -> perf_stall_cyc saturates at 15.
